// File: rtl/seq_detect_ctrl.sv
// Session controller around a Mealy, non-overlapping, bit-serial pattern matcher.
// A start arms the matcher for a window of cycles, and the session ends on the hit limit or on window expiry.
module seq_detect_ctrl #(
  parameter int                PLEN    = 7,
  parameter logic [PLEN-1:0]   PATTERN = 7'b1111001,
  parameter int                WIN_W   = 8,
  parameter int                HIT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] window,
  input  logic [HIT_W-1:0] max_hits,
  input  logic             x,
  input  logic             valid,
  output logic             z,
  output logic             busy,
  output logic             done,
  output logic [HIT_W-1:0] hit_cnt,
  output logic             expired
);

  localparam int              BC_W    = $clog2(PLEN);
  localparam logic [BC_W-1:0] BC_FULL = BC_W'(PLEN - 1);
  localparam logic [HIT_W-1:0] HIT_MAX = {HIT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIN_W-1:0] remaining_reg, remaining_next;
  logic [HIT_W-1:0] limit_reg, limit_next;
  logic [HIT_W-1:0] hit_reg, hit_next;
  logic             expired_reg, expired_next;
  logic [PLEN-2:0]  hist_reg, hist_next;
  logic [BC_W-1:0]  bc_reg, bc_next;

  logic [PLEN-2:0]  hist_shift;
  logic             match_now;
  logic [HIT_W:0]   hit_inc;

  // History shifted by one consumed bit: newest bit lands in position 0.
  assign hist_shift[0] = x;
  generate
    for (genvar gi = 1; gi < PLEN - 1; gi++) begin : g_shift
      assign hist_shift[gi] = hist_reg[gi-1];
    end
  endgenerate

  assign match_now = valid && (bc_reg == BC_FULL) && ({hist_reg, x} == PATTERN);
  // One bit wider so the limit compare cannot wrap when hit_cnt is saturated.
  assign hit_inc   = {1'b0, hit_reg} + {{HIT_W{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      limit_reg     <= '0;
      hit_reg       <= '0;
      expired_reg   <= 1'b0;
      hist_reg      <= '0;
      bc_reg        <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      limit_reg     <= limit_next;
      hit_reg       <= hit_next;
      expired_reg   <= expired_next;
      hist_reg      <= hist_next;
      bc_reg        <= bc_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    limit_next     = limit_reg;
    hit_next       = hit_reg;
    expired_next   = expired_reg;
    hist_next      = hist_reg;
    bc_next        = bc_reg;
    z              = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          remaining_next = window;
          limit_next     = max_hits;
          hit_next       = '0;
          hist_next      = '0;
          bc_next        = '0;
          if (window != '0) begin
            expired_next = 1'b0;
            state_next   = ARMED;
          end else begin
            expired_next = 1'b1;
            state_next   = DONE;
          end
        end
      end

      ARMED: begin
        busy           = 1'b1;
        remaining_next = remaining_reg - 1'b1;
        if (match_now) begin
          z         = 1'b1;
          hist_next = '0;
          bc_next   = '0;
          if (hit_reg != HIT_MAX)
            hit_next = hit_inc[HIT_W-1:0];
        end else if (valid) begin
          hist_next = hist_shift;
          if (bc_reg != BC_FULL)
            bc_next = bc_reg + 1'b1;
        end

        // A hit reaching the limit wins over expiry on the same edge.
        if (match_now && (limit_reg != '0) && (hit_inc >= {1'b0, limit_reg})) begin
          expired_next = 1'b0;
          state_next   = DONE;
        end else if (remaining_reg == {{(WIN_W-1){1'b0}}, 1'b1}) begin
          expired_next = 1'b1;
          state_next   = DONE;
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign hit_cnt = hit_reg;
  assign expired = expired_reg;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: a queue-based session model checked every cycle,
// plus hand-computed per-session expectations.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] window = '0;
  logic [3:0] max_hits = '0;
  logic       x = 1'b0;
  logic       valid = 1'b0;
  logic       z, busy, done, expired;
  logic [3:0] hit_cnt;

  seq_detect_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .window(window), .max_hits(max_hits),
    .x(x), .valid(valid), .z(z), .busy(busy), .done(done),
    .hit_cnt(hit_cnt), .expired(expired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: phase 0=idle 1=armed 2=done; hq holds bits consumed since arm/last match (max 6).
  bit [6:0] pat = 7'b1111001;
  int  m_ph = 0, m_left = 0, m_lim = 0, m_hits = 0;
  bit  m_exp = 0;
  bit  hq[$];

  function automatic bit would_match(input bit xb);
    if (hq.size() != 6) return 0;
    for (int i = 0; i < 6; i++)
      if (hq[i] != pat[6-i]) return 0;
    return xb == pat[0];
  endfunction

  // Monitor counters over DUT outputs, cleared by the stimulus between sessions.
  int zc = 0, dc = 0, bsy = 0;

  always @(negedge clk) begin
    bit ez;
    if (!rst) begin
      check("rst_z", z, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_hits", hit_cnt, 0);
      check("rst_expired", expired, 0);
      m_ph = 0; m_hits = 0; m_exp = 0; m_left = 0; m_lim = 0;
      hq.delete();
    end else begin
      ez = (m_ph == 1) && valid && would_match(x);
      check("z", z, ez);
      check("busy", busy, m_ph == 1);
      check("done", done, m_ph == 2);
      check("hit_cnt", hit_cnt, m_hits);
      check("expired", expired, m_exp);
      zc += z; dc += done; bsy += busy;
      case (m_ph)
        0: if (start) begin
          m_left = window; m_lim = max_hits; m_hits = 0; hq.delete();
          m_exp = (window == 0);
          m_ph = (window != 0) ? 1 : 2;
        end
        1: begin
          if (ez) begin
            hq.delete();
            if (m_lim != 0 && m_hits + 1 >= m_lim) begin m_ph = 2; m_exp = 0; end
            else if (m_left == 1) begin m_ph = 2; m_exp = 1; end
            if (m_hits < 15) m_hits++;
          end else begin
            if (valid) begin
              hq.push_back(x);
              if (hq.size() > 6) void'(hq.pop_front());
            end
            if (m_left == 1) begin m_ph = 2; m_exp = 1; end
          end
          m_left--;
        end
        default: m_ph = 0;
      endcase
    end
  end

  task automatic cyc(input bit s, input bit xb, input bit v);
    start = s; x = xb; valid = v;
    @(posedge clk); #1;
  endtask

  task automatic go(input int w, input int m);
    zc = 0; dc = 0; bsy = 0;
    window = w[7:0]; max_hits = m[3:0];
    cyc(1, 0, 0);
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) cyc(0, bits[i], 1);
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && dc == 0; i++) cyc(0, 0, 0);
    cyc(0, 0, 0);
    check({name, "_done_count"}, dc, 1);
  endtask

  task automatic expect_end(input string name, input int hits, input int ex, input int zs);
    check({name, "_hit_cnt"}, hit_cnt, hits);
    check({name, "_expired"}, expired, ex);
    check({name, "_z_pulses"}, zc, zs);
    $display("session %s: hit_cnt=%0d expired=%0d z_pulses=%0d done=%0d", name, hit_cnt, expired, zc, dc);
  endtask

  initial begin
    repeat (3) cyc(0, 0, 0);
    check("reset_busy", busy, 0);
    check("reset_hits", hit_cnt, 0);
    rst = 1'b1;
    cyc(0, 0, 0);

    // 1: basic match on the 10th bit, limit 1
    go(40, 1);
    send_bits(32'b1101111001, 10);
    wait_done("t1", 5);
    expect_end("t1", 1, 0, 1);

    // 2: non-overlapping, two full patterns, full window
    go(30, 0);
    send_bits(32'b11110011111001, 14);
    wait_done("t2", 40);
    expect_end("t2", 2, 1, 2);
    check("t2_busy_cycles", bsy, 30);

    // 3: valid gaps carrying x=0 do not break the match
    go(20, 0);
    for (int i = 6; i >= 0; i--) begin
      cyc(0, pat[i], 1);
      cyc(0, 0, 0);
    end
    wait_done("t3", 30);
    expect_end("t3", 1, 1, 1);

    // 4a: zero window
    go(0, 3);
    wait_done("t4a", 3);
    expect_end("t4a", 0, 1, 0);
    check("t4a_busy_cycles", bsy, 0);

    // 4b: match on last window cycle, limit reached vs not reached
    go(7, 1);
    send_bits(32'b1111001, 7);
    wait_done("t4b", 3);
    expect_end("t4b", 1, 0, 1);
    go(7, 2);
    send_bits(32'b1111001, 7);
    wait_done("t4b2", 3);
    expect_end("t4b2", 1, 1, 1);

    // 4c: saturation after 16 matches
    go(120, 0);
    for (int k = 0; k < 16; k++) send_bits(32'b1111001, 7);
    wait_done("t4c", 20);
    expect_end("t4c", 15, 1, 16);

    // 5a: start held through ARMED and DONE
    zc = 0; dc = 0; bsy = 0;
    window = 8'd10; max_hits = 4'd0;
    repeat (12) cyc(1, 1, 1);
    repeat (3) cyc(0, 0, 0);
    check("t5a_done_count", dc, 1);
    check("t5a_busy_cycles", bsy, 10);

    // 5b: reset mid-session
    go(50, 0);
    send_bits(32'b1111001110, 10);
    check("t5b_hits_before", hit_cnt, 1);
    rst = 1'b0; #1;
    check("t5b_busy_rst", busy, 0);
    check("t5b_hits_rst", hit_cnt, 0);
    check("t5b_z_rst", z, 0);
    cyc(0, 1, 1);
    cyc(0, 1, 1);
    rst = 1'b1;
    repeat (3) cyc(0, 0, 0);
    check("t5b_no_done", dc, 0);
    go(40, 1);
    send_bits(32'b1101111001, 10);
    wait_done("t5b_after", 5);
    expect_end("t5b_after", 1, 0, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d", passes, checks);
    $fatal(1);
  end

endmodule
